// File: rtl/snake_grid_pkg.sv
// Shared constants and types for the snake grid RAM subsystem.
//  - Cell codes stored in the grid RAM.
//  - Grid geometry and 640x480 visible-area constants.
//  - Read-owner tag and arbiter state encodings.
package snake_grid_pkg;

  localparam int GRID_W       = 40;
  localparam int GRID_H       = 30;
  localparam int H_VISIBLE_PX = 640;
  localparam int V_VISIBLE_LN = 480;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_BODY  = 2'd1;
  localparam logic [1:0] CELL_HEAD  = 2'd2;
  localparam logic [1:0] CELL_FOOD  = 2'd3;

  // Which requester the RAM read data returning this cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_GM   = 2'd2
  } owner_e;

  // ST_GAME is a transient phase: a game access is granted and completed
  // within one IDLE cycle, so the register never holds it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAME  = 2'd1,
    ST_CLEAR = 2'd2
  } arb_st_e;

endpackage

// File: rtl/grid_ram_arbiter_game_tick_gen.sv
// game_tick_gen: frame-rate divider for the game step pulse.
//  clk, rst     : pixel clock, asynchronous active-high reset
//  x, y         : pixel/line counters from the timing generator
//  tick_en      : 0 freezes the divider (game paused)
//  game_tick    : 1-cycle pulse on the frame event where the divider expires
// The frame event is the first pixel of the first non-visible line, so the
// game state updates at the start of vertical blanking.
module game_tick_gen
  import snake_grid_pkg::*;
#(
  parameter int V_VIS    = V_VISIBLE_LN,
  parameter int TICK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       tick_en,
  output logic       game_tick
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          frame_evt;
  logic          adv;

  assign frame_evt = (y == 10'(V_VIS)) && (x == 10'd0);
  assign adv       = frame_evt && tick_en && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (adv) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

  // Pulse coincides with the frame event itself, not one cycle later.
  assign game_tick = adv && (cnt == '0);

endmodule

// File: rtl/grid_ram_arbiter.sv
// grid_ram_arbiter: shares the single-port snake grid RAM between the video
// cell fetcher (highest priority, never stalled), the board-clear engine and
// the game-logic FSM, and generates game_tick at the start of vblank.
//  clk, rst                  : pixel clock, asynchronous active-high reset
//  x, y                      : timing-generator counters
//  vid_req/vid_addr          : video read request (1 cycle)
//  vid_rdata/vid_rvalid      : video read return, 1 cycle after vid_req
//  gm_req/we/addr/wdata      : game access, held until gm_gnt
//  gm_gnt                    : access issued to the RAM this cycle
//  gm_rdata/gm_rvalid        : game read return, 1 cycle after gm_gnt
//  clr_start/busy/done       : full-board clear control
//  tick_en/game_tick         : game step pulse generation
//  ram_en/we/addr/wdata/rdata: single-port RAM with 1-cycle read latency
//  gm_stall_max              : only with GRID_ARB_STATS_EN defined; longest
//                              run of cycles gm_req waited without a grant
module grid_ram_arbiter
  import snake_grid_pkg::*;
#(
  parameter int DEPTH     = 1200,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 2,
  parameter int CLEAR_VAL = 0,
  parameter int V_VISIBLE = V_VISIBLE_LN,
  parameter int TICK_DIV  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              gm_req,
  input  logic              gm_we,
  input  logic [ADDR_W-1:0] gm_addr,
  input  logic [DATA_W-1:0] gm_wdata,
  output logic              gm_gnt,
  output logic [DATA_W-1:0] gm_rdata,
  output logic              gm_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              tick_en,
  output logic              game_tick,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef GRID_ARB_STATS_EN
  ,
  output logic [15:0]       gm_stall_max
`endif
);

  arb_st_e           st;
  owner_e            owner;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] vid_hold;
  logic [DATA_W-1:0] gm_hold;
  logic              run;
  logic              vid_go;
  logic              clr_go;
  logic              gm_go;
  logic              clr_last;

  // Combinational grant outputs are forced low while reset is asserted.
  assign run      = !rst;
  assign vid_go   = run && vid_req;
  assign clr_go   = run && (st == ST_CLEAR) && !vid_req;
  // A clr_start arriving in IDLE takes precedence over a pending game request.
  assign gm_go    = run && (st == ST_IDLE) && gm_req && !vid_req && !clr_start;
  assign clr_last = clr_go && (clr_addr == ADDR_W'(DEPTH - 1));
  assign gm_gnt   = gm_go;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (vid_go) begin
      ram_en   = 1'b1;
      ram_addr = vid_addr;
    end else if (clr_go) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = DATA_W'(CLEAR_VAL);
    end else if (gm_go) begin
      ram_en    = 1'b1;
      ram_we    = gm_we;
      ram_addr  = gm_addr;
      ram_wdata = gm_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      clr_addr <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      owner    <= OWN_NONE;
      vid_hold <= '0;
      gm_hold  <= '0;
    end else begin
      clr_done <= clr_last;
      case (st)
        ST_IDLE: begin
          if (clr_start) begin
            st       <= ST_CLEAR;
            clr_busy <= 1'b1;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          // clr_start is ignored here; only the sweep end leaves CLEAR.
          if (clr_go) begin
            if (clr_last) begin
              st       <= ST_IDLE;
              clr_busy <= 1'b0;
              clr_addr <= '0;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
      // Tag the read issued this cycle so its data returns to the right port.
      if (vid_go)              owner <= OWN_VID;
      else if (gm_go && !gm_we) owner <= OWN_GM;
      else                     owner <= OWN_NONE;
      if (owner == OWN_VID) vid_hold <= ram_rdata;
      if (owner == OWN_GM)  gm_hold  <= ram_rdata;
    end
  end

  // Returning data passes straight through; the other port keeps its last value.
  assign vid_rvalid = (owner == OWN_VID);
  assign gm_rvalid  = (owner == OWN_GM);
  assign vid_rdata  = vid_rvalid ? ram_rdata : vid_hold;
  assign gm_rdata   = gm_rvalid ? ram_rdata : gm_hold;

  game_tick_gen #(
    .V_VIS    (V_VISIBLE),
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .tick_en   (tick_en),
    .game_tick (game_tick)
  );

`ifdef GRID_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_run;
  logic [15:0] stall_nxt;

  assign stall_nxt = sat_inc16(stall_run);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_run    <= '0;
      gm_stall_max <= '0;
    end else if (clr_start) begin
      stall_run    <= '0;
      gm_stall_max <= '0;
    end else if (gm_req && !gm_go) begin
      stall_run <= stall_nxt;
      if (stall_nxt > gm_stall_max) gm_stall_max <= stall_nxt;
    end else begin
      stall_run <= '0;
    end
  end
`endif

endmodule
